// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: oversample tick, 1x bit tick and legacy baud clock,
// with a shadowed divisor that only takes effect at a period boundary.
module uart_baud_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [DIV_W-1:0]  DIVISOR,
  input  logic [FRAC_W-1:0] DIV_FRAC,
  input  logic              DIV_LOAD,
  input  logic              SYNC,
  output logic              X_TICK,
  output logic              BAUD_TICK,
  output logic              BAUDOUT_CLK,
  output logic              DIV_PEND
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_ONE  = OVS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0]  div_act, div_sh, cnt;
  logic [FRAC_W-1:0] frac_act, frac_sh, acc;
  logic [OVS_W-1:0]  ovs_cnt;
  logic              pend;
  logic              x_tick, baud_tick, baudout_clk;

  logic              running, terminal, baud_hi;
  logic [DIV_W-1:0]  div_new, div_stop, reload;
  logic [FRAC_W-1:0] frac_new;
  logic [FRAC_W:0]   acc_sum;

  function automatic logic [DIV_W-1:0] dec_sat(input logic [DIV_W-1:0] v);
    return (v == '0) ? '0 : v - DIV_ONE;
  endfunction

  assign running  = EN && (div_act != '0);
  assign terminal = running && !SYNC && (cnt == '0);
  assign div_stop = DIV_LOAD ? DIVISOR : div_act;

  // Divisor in effect after a boundary: a same-cycle load beats a waiting shadow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    div_new  = div_act;
    frac_new = frac_act;
    reload   = '0;
    if (DIV_LOAD) begin
      div_new  = DIVISOR;
      frac_new = DIV_FRAC;
    end else if (pend) begin
      div_new  = div_sh;
      frac_new = frac_sh;
    end
    acc_sum = {1'b0, acc} + {1'b0, frac_new};
    if (div_new != '0)
      reload = div_new - DIV_ONE + DIV_W'(acc_sum[FRAC_W]);
  end

  // A boundary that loads divisor 0 must not leave the baud clock high for a cycle.
  assign baud_hi = running && !(terminal && (div_new == '0)) && (cnt >= (div_act >> 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_act     <= '0;
      frac_act    <= '0;
      div_sh      <= '0;
      frac_sh     <= '0;
      cnt         <= '0;
      acc         <= '0;
      ovs_cnt     <= '0;
      pend        <= 1'b0;
      x_tick      <= 1'b0;
      baud_tick   <= 1'b0;
      baudout_clk <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      x_tick      <= 1'b0;
      baud_tick   <= 1'b0;
      baudout_clk <= baud_hi;
      if (!running) begin
        if (DIV_LOAD) begin
          div_act  <= DIVISOR;
          frac_act <= DIV_FRAC;
          pend     <= 1'b0;
        end
        cnt     <= dec_sat(div_stop);
        acc     <= '0;
        ovs_cnt <= '0;
      end else if (SYNC || (cnt != '0)) begin
        if (SYNC) begin
          cnt     <= dec_sat(div_act);
          acc     <= '0;
          ovs_cnt <= '0;
        end else begin
          cnt <= cnt - DIV_ONE;
        end
        if (DIV_LOAD) begin
          div_sh  <= DIVISOR;
          frac_sh <= DIV_FRAC;
          pend    <= 1'b1;
        end
      end else begin
        div_act  <= div_new;
        frac_act <= frac_new;
        pend     <= 1'b0;
        acc      <= acc_sum[FRAC_W-1:0];
        cnt      <= reload;
        if (div_new != '0) begin
          x_tick    <= 1'b1;
          baud_tick <= (ovs_cnt == OVS_LAST);
          ovs_cnt   <= ovs_cnt + OVS_ONE;
        end
      end
    end
  end

  assign X_TICK      = x_tick;
  assign BAUD_TICK   = baud_tick;
  assign BAUDOUT_CLK = baudout_clk;
  assign DIV_PEND    = pend;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: free-running periods are predicted from tick
// arithmetic (D plus the carries of j*F/2^FRAC_W), directed tasks cover loads, SYNC and stop.
module tb_uart_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
  localparam int FSTEPS = 1 << FRAC_W;

  logic              CLK, RST_N, EN, DIV_LOAD, SYNC;
  logic [DIV_W-1:0]  DIVISOR;
  logic [FRAC_W-1:0] DIV_FRAC;
  logic              X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND;

  int checks = 0;
  int errors = 0;

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .DIVISOR(DIVISOR), .DIV_FRAC(DIV_FRAC),
    .DIV_LOAD(DIV_LOAD), .SYNC(SYNC), .X_TICK(X_TICK), .BAUD_TICK(BAUD_TICK),
    .BAUDOUT_CLK(BAUDOUT_CLK), .DIV_PEND(DIV_PEND)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Stop, load d/f while stopped, and let the outputs settle to the stopped state.
  task automatic restart(input int d, input int f);
    EN       = 1'b0;
    SYNC     = 1'b0;
    DIV_LOAD = 1'b1;
    DIVISOR  = DIV_W'(d);
    DIV_FRAC = FRAC_W'(f);
    step();
    DIV_LOAD = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; EN = 1'b0; SYNC = 1'b0; DIV_LOAD = 1'b0; DIVISOR = '0; DIV_FRAC = '0;
    step();
    step();
    checks++;
    if ({X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000", {X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND});
    end
    RST_N = 1'b1;
    EN    = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if ({X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_stays_stopped cycle %0d: got %b, expected 0000", n,
                 {X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND});
      end
    end
    EN = 1'b0;
  endtask

  // Free run from a clean start; cycle 0 is the first cycle with EN=1.
  task automatic test_free_run(input int d, input int f, input int ncyc, output int span16);
    int ticks[$];
    int obs[$];
    int t, j, k;
    logic ex, eb, ebo;
    restart(d, f);
    t = d;
    j = 1;
    while (t <= ncyc + d + 2) begin
      ticks.push_back(t);
      t = t + d + (j * f) / FSTEPS - ((j - 1) * f) / FSTEPS;
      j++;
    end
    k = 0;
    for (int n = 0; n <= ncyc; n++) begin
      while (ticks[k] < n) k++;
      ex  = (ticks[k] == n);
      eb  = ex && (((k + 1) % OVS) == 0);
      ebo = (n >= 1) && ((ticks[k] - n) >= d / 2);
      checks++;
      if (X_TICK !== ex) begin
        errors++;
        $display("FAIL free_x_tick d=%0d f=%0d cycle %0d: got %b, expected %b", d, f, n, X_TICK, ex);
      end
      checks++;
      if (BAUD_TICK !== eb) begin
        errors++;
        $display("FAIL free_baud_tick d=%0d f=%0d cycle %0d: got %b, expected %b", d, f, n, BAUD_TICK, eb);
      end
      checks++;
      if (BAUDOUT_CLK !== ebo) begin
        errors++;
        $display("FAIL free_baudout d=%0d f=%0d cycle %0d: got %b, expected %b", d, f, n, BAUDOUT_CLK, ebo);
      end
      checks++;
      if (DIV_PEND !== 1'b0) begin
        errors++;
        $display("FAIL free_pend d=%0d f=%0d cycle %0d: got %b, expected 0", d, f, n, DIV_PEND);
      end
      if (X_TICK === 1'b1) obs.push_back(n);
      if (n == 0) EN = 1'b1;
      step();
    end
    span16 = (obs.size() > 16) ? obs[16] - obs[0] : -1;
  endtask

  task automatic test_basic();
    int span;
    test_free_run(5, 0, 170, span);
    test_free_run(1, 0, 40, span);
  endtask

  task automatic test_fraction();
    int span;
    test_free_run(4, 8, 100, span);
    checks++;
    if (span !== 16 * 4 + 8) begin
      errors++;
      $display("FAIL fraction_span16: got %0d cycles, expected %0d", span, 16 * 4 + 8);
    end
  endtask

  task automatic test_random();
    int d, f, span;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(1, 12);
      f = $urandom_range(0, FSTEPS - 1);
      test_free_run(d, f, 17 * (d + 1) + 10, span);
      checks++;
      if (span !== 16 * d + f) begin
        errors++;
        $display("FAIL random_span16 d=%0d f=%0d: got %0d, expected %0d", d, f, span, 16 * d + f);
      end
    end
  endtask

  task automatic test_divisor_update();
    logic ex, ep;
    restart(10, 0);
    for (int n = 0; n <= 42; n++) begin
      ex = (n > 0 && n <= 30 && (n % 10) == 0) || (n > 30 && ((n - 30) % 3) == 0);
      ep = (n >= 23 && n <= 29);
      checks++;
      if (X_TICK !== ex) begin
        errors++;
        $display("FAIL update_x_tick cycle %0d: got %b, expected %b", n, X_TICK, ex);
      end
      checks++;
      if (DIV_PEND !== ep) begin
        errors++;
        $display("FAIL update_pend cycle %0d: got %b, expected %b", n, DIV_PEND, ep);
      end
      if (n == 0) EN = 1'b1;
      DIV_LOAD = (n == 22 || n == 23);
      DIVISOR  = (n == 22) ? DIV_W'(7) : DIV_W'(3);
      DIV_FRAC = '0;
      step();
    end
    DIV_LOAD = 1'b0;
  endtask

  task automatic test_load_at_terminal();
    logic ex;
    restart(6, 0);
    for (int n = 0; n <= 22; n++) begin
      ex = (n == 6) || (n == 12) || (n > 12 && ((n - 12) % 2) == 0);
      checks++;
      if (X_TICK !== ex) begin
        errors++;
        $display("FAIL term_load_x_tick cycle %0d: got %b, expected %b", n, X_TICK, ex);
      end
      checks++;
      if (DIV_PEND !== 1'b0) begin
        errors++;
        $display("FAIL term_load_pend cycle %0d: got %b, expected 0", n, DIV_PEND);
      end
      if (n == 0) EN = 1'b1;
      DIV_LOAD = (n == 11);
      DIVISOR  = DIV_W'(2);
      step();
    end
    DIV_LOAD = 1'b0;
  endtask

  task automatic test_sync();
    int s;
    logic ex, eb;
    s = 16 + $urandom_range(0, 7);
    restart(8, 0);
    for (int n = 0; n <= s + 140; n++) begin
      ex = (n == 8) || (n == 16) || (n >= s + 9 && ((n - s - 9) % 8) == 0);
      eb = (n == s + 9 + 15 * 8);
      checks++;
      if (X_TICK !== ex) begin
        errors++;
        $display("FAIL sync_x_tick s=%0d cycle %0d: got %b, expected %b", s, n, X_TICK, ex);
      end
      checks++;
      if (BAUD_TICK !== eb) begin
        errors++;
        $display("FAIL sync_baud_tick s=%0d cycle %0d: got %b, expected %b", s, n, BAUD_TICK, eb);
      end
      if (n == 0) EN = 1'b1;
      SYNC = (n == s);
      step();
    end
    SYNC = 1'b0;
  endtask

  task automatic test_stop();
    int span;
    logic ex, ep;
    restart(5, 0);
    for (int n = 0; n <= 40; n++) begin
      ex = (n == 5);
      ep = (n == 8 || n == 9);
      checks++;
      if (X_TICK !== ex) begin
        errors++;
        $display("FAIL stop_x_tick cycle %0d: got %b, expected %b", n, X_TICK, ex);
      end
      checks++;
      if (DIV_PEND !== ep) begin
        errors++;
        $display("FAIL stop_pend cycle %0d: got %b, expected %b", n, DIV_PEND, ep);
      end
      if (n >= 10) begin
        checks++;
        if ({BAUD_TICK, BAUDOUT_CLK} !== 2'b00) begin
          errors++;
          $display("FAIL stop_outputs cycle %0d: got %b, expected 00", n, {BAUD_TICK, BAUDOUT_CLK});
        end
      end
      if (n == 0) EN = 1'b1;
      if (n >= 12) EN = 1'($urandom_range(0, 1));
      DIV_LOAD = (n == 7);
      DIVISOR  = '0;
      step();
    end
    DIV_LOAD = 1'b0;
    test_free_run(3, 0, 60, span);
  endtask

  task automatic test_en_fall();
    logic ex;
    restart(1, 0);
    for (int n = 0; n <= 12; n++) begin
      ex = (n >= 1 && n <= 6);
      checks++;
      if (X_TICK !== ex) begin
        errors++;
        $display("FAIL en_fall_x_tick cycle %0d: got %b, expected %b", n, X_TICK, ex);
      end
      EN = (n < 6);
      step();
    end
  endtask

  task automatic test_reset_mid();
    restart(1, 0);
    EN = 1'b1;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if ({X_TICK, BAUDOUT_CLK} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pre: got %b, expected 11", {X_TICK, BAUDOUT_CLK});
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async: got %b, expected 0000", {X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND});
    end
    step();
    RST_N = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++;
      if ({X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_after cycle %0d: got %b, expected 0000", n,
                 {X_TICK, BAUD_TICK, BAUDOUT_CLK, DIV_PEND});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fraction();
    test_random();
    test_divisor_update();
    test_load_at_terminal();
    test_sync();
    test_stop();
    test_en_fall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
